// File: rtl/fsgn_opstage_pkg.sv
// ============================================================================
// Module      : fsgn_opstage_pkg
// Description : Shared FPU constants and types for the sign-injection
//               operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsgn_opstage_pkg;

   localparam logic        c_FMT_S        = 1'b0;
   localparam logic        c_FMT_D        = 1'b1;
   localparam logic [63:0] c_CANON_NAN_S  = 64'hFFFFFFFF_7FC00000;

   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      logic [63:0] x;
      logic        xs;
      logic        ys;
      logic        fmt;
      logic [1:0]  op_ctrl;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/fsgn_opstage_boxchk.sv
// ============================================================================
// Module      : fsgn_boxchk
// Description : NaN-box check and sign extraction for one FP operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsgn_boxchk
   import fsgn_opstage_pkg::*;
#(
   parameter int FLEN = 64,
   parameter int LEN1 = 32
) (
   input  logic [FLEN-1:0] op_in,
   input  logic            fmt_in,
   output logic [FLEN-1:0] op_chk,
   output logic            sign,
   output logic            bad
);

   // A single-precision value is legal only when its upper half is all ones.
   assign bad    = (fmt_in == c_FMT_S) && !(&op_in[FLEN-1:LEN1]);
   assign op_chk = bad ? c_CANON_NAN_S : op_in;
   assign sign   = (fmt_in == c_FMT_D) ? op_chk[FLEN-1] : op_chk[LEN1-1];

endmodule

`default_nettype wire

// File: rtl/fsgn_opstage.sv
// ============================================================================
// Module      : fsgn_opstage
// Description : Operand stage for FP sign injection: box check, sign
//               extraction and a 2-entry skid FIFO with unboxed counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsgn_opstage
   import fsgn_opstage_pkg::*;
#(
   parameter int FLEN = 64,
   parameter int LEN1 = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            Flush,
   input  logic            InValid,
   output logic            InReady,
   input  logic [FLEN-1:0] XIn,
   input  logic [FLEN-1:0] YIn,
   input  logic            FmtIn,
   input  logic [1:0]      OpCtrlIn,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [FLEN-1:0] X,
   output logic            Xs,
   output logic            Ys,
   output logic            Fmt,
   output logic [1:0]      OpCtrl,
   output logic [CNTW-1:0] UnboxCnt
);

   logic [FLEN-1:0] w_x_chk;
   logic [FLEN-1:0] w_y_chk;
   logic            w_xs;
   logic            w_ys;
   logic            w_x_bad;
   logic            w_y_bad;
   logic            w_unused_y;
   logic            w_in_xfer;
   logic            w_out_xfer;
   logic            w_in_take;
   logic [CNTW:0]   w_unbox_sum;
   entry_t          w_new;

   occ_e            cnt_q, cnt_d;
   entry_t          main_q, main_d;
   entry_t          skid_q, skid_d;
   logic [CNTW-1:0] unbox_cnt_q, unbox_cnt_d;

   fsgn_boxchk #(.FLEN(FLEN), .LEN1(LEN1)) u_boxchk_x (
      .op_in  (XIn),
      .fmt_in (FmtIn),
      .op_chk (w_x_chk),
      .sign   (w_xs),
      .bad    (w_x_bad)
   );

   fsgn_boxchk #(.FLEN(FLEN), .LEN1(LEN1)) u_boxchk_y (
      .op_in  (YIn),
      .fmt_in (FmtIn),
      .op_chk (w_y_chk),
      .sign   (w_ys),
      .bad    (w_y_bad)
   );

   // Only the sign of Y travels downstream.
   assign w_unused_y = ^w_y_chk;

   assign InReady    = (cnt_q != CNT_FULL);
   assign OutValid   = (cnt_q != CNT_EMPTY);
   assign w_in_xfer  = InValid & InReady;
   assign w_out_xfer = OutValid & OutReady;
   assign w_in_take  = w_in_xfer & ~Flush;

   always_comb begin
      w_new         = '0;
      w_new.x       = w_x_chk;
      w_new.xs      = w_xs;
      w_new.ys      = w_ys;
      w_new.fmt     = FmtIn;
      w_new.op_ctrl = OpCtrlIn;
   end

   always_comb begin
      cnt_d  = cnt_q;
      main_d = main_q;
      skid_d = skid_q;
      if (Flush) begin
         cnt_d = CNT_EMPTY;
      end else begin
         case (cnt_q)
            CNT_EMPTY: begin
               if (w_in_xfer) begin
                  main_d = w_new;
                  cnt_d  = CNT_ONE;
               end
            end
            CNT_ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  main_d = w_new;
               end else if (w_in_xfer) begin
                  skid_d = w_new;
                  cnt_d  = CNT_FULL;
               end else if (w_out_xfer) begin
                  cnt_d  = CNT_EMPTY;
               end
            end
            CNT_FULL: begin
               if (w_out_xfer) begin
                  main_d = skid_q;
                  cnt_d  = CNT_ONE;
               end
            end
            default: cnt_d = CNT_EMPTY;
         endcase
      end
   end

   always_comb begin
      w_unbox_sum = {1'b0, unbox_cnt_q} + {{CNTW{1'b0}}, w_x_bad}
                                        + {{CNTW{1'b0}}, w_y_bad};
      unbox_cnt_d = unbox_cnt_q;
      if (w_in_take) begin
         unbox_cnt_d = w_unbox_sum[CNTW] ? {CNTW{1'b1}} : w_unbox_sum[CNTW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= CNT_EMPTY;
         unbox_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         unbox_cnt_q <= unbox_cnt_d;
      end
   end

   // Payload registers carry no reset; occupancy alone qualifies them.
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   assign X        = main_q.x;
   assign Xs       = main_q.xs;
   assign Ys       = main_q.ys;
   assign Fmt      = main_q.fmt;
   assign OpCtrl   = main_q.op_ctrl;
   assign UnboxCnt = unbox_cnt_q;

endmodule

`default_nettype wire

// File: doc/fsgn_opstage.md
FSGN_OPSTAGE -- requirements
Module: fsgn_opstage

Interface
REQ-001 Parameter FLEN, default 64, full FP register width; FLEN SHALL be 64.
REQ-002 Parameter LEN1, default 32, single-precision width; LEN1 SHALL be 32.
REQ-003 Parameter CNTW, default 16, width of unboxed-operand counter.
REQ-004 Port clk input 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n input 1: reset, asynchronous and active-low.
REQ-006 Port Flush input 1: synchronous discard of all held entries.
REQ-007 Port InValid input 1: upstream offers an operand pair.
REQ-008 Port InReady output 1: stage can accept this cycle.
REQ-009 Port XIn input FLEN: raw X operand from register file.
REQ-010 Port YIn input FLEN: raw Y operand from register file.
REQ-011 Port FmtIn input 1: 1 = double, 0 = single.
REQ-012 Port OpCtrlIn input 2: sign-injection opcode, passed through unchanged.
REQ-013 Port OutValid output 1: output entry present.
REQ-014 Port OutReady input 1: downstream sign-injection stage consumes.
REQ-015 Port X output FLEN: box-checked X operand.
REQ-016 Port Xs output 1, and port Ys output 1: extracted sign bits of the box-checked X and Y.
REQ-017 Port Fmt output 1, and port OpCtrl output 2: registered copies of FmtIn and OpCtrlIn.
REQ-018 Port UnboxCnt output CNTW: saturating count of improperly boxed operands accepted.

Function
REQ-019 A transfer in SHALL occur when InValid and InReady are both 1 in a cycle; a transfer out SHALL occur when OutValid and OutReady are both 1.
REQ-020 The stage SHALL hold a 2-entry FIFO (main register plus skid register); outputs SHALL come from the oldest entry only.
REQ-021 InReady SHALL be 1 when fewer than 2 entries are held, and SHALL depend only on registered state.
REQ-022 Latency SHALL be 1 cycle: data accepted at edge N appears on the outputs after edge N when the FIFO was empty.
REQ-023 At 2 entries with a simultaneous out-transfer, InReady SHALL remain 0 that cycle.
REQ-024 At 1 entry with simultaneous in and out transfers, the count SHALL stay 1 and the new data SHALL become the output.
REQ-025 At 0 entries, OutValid SHALL be 0; output data values are then don't-care.
REQ-026 If FmtIn=0 and an operand's bits [63:32] are not all 1, that operand SHALL be replaced by the canonical boxed NaN 64'hFFFFFFFF_7FC00000.
REQ-027 If FmtIn=1, operands SHALL pass unmodified.
REQ-028 For single, Xs/Ys SHALL be bit 31 of the checked operand; for double, bit 63.
REQ-029 Box check and sign extraction SHALL be done before the FIFO write; stored entries hold checked values.
REQ-030 UnboxCnt SHALL add 0, 1 or 2 per in-transfer (one per bad operand) and saturate at all-ones.
REQ-031 Flush SHALL set the count to 0 the next cycle and override a same-cycle in-transfer; UnboxCnt SHALL not be altered by Flush.

Reset
REQ-032 reset_n low SHALL immediately clear the entry count to 0 and force OutValid=0, InReady=1 and UnboxCnt=0.
REQ-033 Reset asserted mid-transfer SHALL discard all entries; data registers need not be reset.
REQ-034 The first transfer after reset_n deasserts SHALL be possible at the first rising clk edge.

Structure
REQ-035 The canonical single NaN constant and the FMT encodings (S=0, D=1) SHALL live in the shared FPU package.
REQ-036 One sub-module fsgn_boxchk (combinational: operand, Fmt -> checked operand, sign, bad flag) SHALL be instantiated twice, once for X and once for Y.

Verification
REQ-037 Reset then FmtIn=1, XIn=64'h8000000000000000, YIn=64'h3FF0000000000000, OpCtrlIn=2'b01, OutReady=1 -> next cycle OutValid=1, Xs=1, Ys=0, X unchanged, UnboxCnt=0.
REQ-038 FmtIn=0, XIn=64'h00000000_BF800000, YIn=64'hFFFFFFFF_3F800000 -> X=64'hFFFFFFFF_7FC00000, Xs=0, Ys=0, UnboxCnt=1.
REQ-039 OutReady=0 with 3 back-to-back InValid beats -> InReady drops after 2 acceptances; release OutReady -> entries exit in order A, B, then C accepted.
REQ-040 One entry held, InValid=1 and OutReady=1 every cycle for 10 cycles -> 10 in-transfers and 10 out-transfers, zero bubbles.
REQ-041 Preload UnboxCnt=16'hFFFE, then send one double-bad single pair -> UnboxCnt=16'hFFFF and stays there on further bad pairs.
REQ-042 Two entries held, assert Flush with InValid=1, then separately drop reset_n asynchronously mid-cycle -> Flush leaves OutValid=0 next cycle and the beat is dropped; reset gives OutValid=0 and InReady=1 before the next edge.
